csr_regfile: RTL and testbench
==============================

# csr_regfile

Control/status register file answering the write-back stage's CSR port in the LoongArch pipeline. Serves combinational reads by `csr_num` and applies masked writes at the clock edge. Also applies the exception-commit and `ertn` side effects raised by write-back, and supplies exception/return entry addresses and the interrupt-pending flag back to the pipeline. Includes the stable-timer counter.

## Interface
- No parameters; CSR numbers and field positions live in the shared package.
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `csr_re` in 1: read strobe; informational only, the read port is always live.
- `csr_num` in 14: CSR address for both read and write.
- `csr_rvalue` out 32: combinational read data for `csr_num`.
- `csr_we` in 1: write enable.
- `csr_wmask` in 32: bit-level write mask.
- `csr_wvalue` in 32: write data.
- `wb_ex` in 1: exception commit.
- `ertn_flush` in 1: `ertn` commit.
- `wb_pc` in 32: PC of the committing instruction.
- `wb_ecode` in 6: exception code.
- `wb_esubcode` in 9: exception subcode.
- `hw_int_in` in 8: level hardware interrupts, sampled every cycle.
- `ipi_int_in` in 1: inter-processor interrupt level.
- `ex_entry` out 32: equals EENTRY.
- `ertn_entry` out 32: equals ERA.
- `has_int` out 1: interrupt pending and enabled.

## Operation
- Implemented CSRs and reset values:
  - CRMD 0x0: PLV[1:0]=0, IE[2]=0, DA[3]=1.
  - PRMD 0x1: PPLV[1:0], PIE[2]; reset 0.
  - ECFG 0x4: LIE[9:0], LIE[12:11]; reset 0.
  - ESTAT 0x5: IS[1:0] software-writable, IS[9:2] = `hw_int_in` (registered), IS[11] timer, IS[12] = `ipi_int_in` (registered), Ecode[21:16], EsubCode[30:22]; reset 0.
  - ERA 0x6: reset 0.
  - EENTRY 0xC: VA[31:6] writable, [5:0] read 0; reset 0.
  - SAVE0–3 0x30–0x33: reset 0.
  - TID 0x40, TCFG 0x41, TVAL 0x42 (read-only), TICLR 0x44 (reads 0).
- Unimplemented `csr_num` reads 0; writes to it are dropped. Non-writable bits are unaffected by any mask.
- Masked write: new = (old & ~wmask) | (wvalue & wmask), applied at the edge.
- `wb_ex`:
  - PRMD.PPLV ← CRMD.PLV, PRMD.PIE ← CRMD.IE.
  - CRMD.PLV ← 0, CRMD.IE ← 0.
  - ERA ← `wb_pc`.
  - ESTAT.Ecode/EsubCode ← `wb_ecode`/`wb_esubcode`.
- `ertn_flush`: CRMD.PLV ← PRMD.PPLV, CRMD.IE ← PRMD.PIE.
- Priority: `wb_ex` > `ertn_flush` > `csr_we`, resolved per field. A `csr_we` in the same cycle as `wb_ex` or `ertn_flush` is dropped entirely.
- Timer:
  - A TCFG write with new En=1 loads TVAL ← {InitVal[31:2], 2'b00}.
  - Otherwise, while En=1 and TVAL≠0xFFFFFFFF:
    - TVAL=0 and Periodic=1: TVAL reloads {InitVal, 2'b00}.
    - Else: TVAL ← TVAL−1.
  - With En=1 and TVAL=0, IS[11] is set on the next edge.
  - A TICLR write with wvalue[0]&wmask[0] clears IS[11]. Set and clear in the same cycle: clear wins.
  - En=0 freezes TVAL.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).

## Timing
- Reads are zero-latency combinational.
- Read-during-write returns the pre-edge value.
- Writes and side effects are visible one cycle after the asserting edge.
- `ex_entry`, `ertn_entry` and `has_int` are combinational from registered state only. There is no path from the write inputs to these outputs.
- Hardware and IPI interrupts reach IS one cycle after sampling.
- Asynchronous reset forces every register to its reset value immediately, mid-count included. All outputs reflect the reset values while `reset` is high: `csr_rvalue` for CRMD reads 0x8, `has_int`=0, and `ex_entry`=`ertn_entry`=0.

## Configuration
- `CSR_TIMER_EN` defined: TID, TCFG, TVAL, TICLR and IS[11] are implemented as above.
- `CSR_TIMER_EN` undefined:
  - The timer logic is removed; addresses 0x40–0x44 read 0 and ignore writes.
  - IS[11] is tied to 0.

## Structure
- Shared package `csr_defs`: CSR numbers (CSR_CRMD … CSR_TICLR) and field bit positions/widths (PLV, IE, DA, PPLV, PIE, LIE, IS, ECODE, ESUBCODE, EENTRY_VA, TCFG_EN, TCFG_PERIODIC, TCFG_INITV).
- One sub-module `csr_timer`: holds TCFG/TVAL, produces the timer-interrupt set pulse, and takes the TICLR clear. Instantiated only under `CSR_TIMER_EN`.

## Test plan
- Reset, then read CRMD → 0x00000008. Read EENTRY → 0. `has_int`=0.
- Write SAVE2 with wvalue=0xDEADBEEF, wmask=0xFFFF0000 → read 0xDEAD0000. The same-cycle read returns 0.
- Set CRMD.PLV=3 and IE=1, then `wb_ex` with pc=0x1C000100, ecode=0xB → CRMD=0x8, PRMD=0x7, ERA=0x1C000100, ESTAT[21:16]=0xB. A following `ertn_flush` → CRMD=0xF.
- Assert `wb_ex` and `csr_we` to ERA (0x12345678) together → ERA=`wb_pc`; the write is ignored.
- Write TCFG=0x0000000B (InitVal=8, periodic, En), ECFG.LIE[11]=1, CRMD.IE=1:
  - TVAL counts 8→0; IS[11] and `has_int` rise; TVAL reloads to 8.
  - A TICLR write of 1 clears IS[11].
- Set `hw_int_in`=0x04 with LIE[4]=1 and IE=1 → `has_int` rises one cycle later. Assert `reset` mid-count → TVAL and all CSRs return to reset values asynchronously.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
// Shared CSR numbers, field positions and the masked-merge helper for csr_regfile.
// Package name is csr_defs so the pipeline can import it by that name.
package csr_defs;

  typedef logic [13:0] csr_num_t;

  localparam csr_num_t CSR_CRMD   = 14'h000;
  localparam csr_num_t CSR_PRMD   = 14'h001;
  localparam csr_num_t CSR_ECFG   = 14'h004;
  localparam csr_num_t CSR_ESTAT  = 14'h005;
  localparam csr_num_t CSR_ERA    = 14'h006;
  localparam csr_num_t CSR_EENTRY = 14'h00c;
  localparam csr_num_t CSR_SAVE0  = 14'h030;
  localparam csr_num_t CSR_SAVE1  = 14'h031;
  localparam csr_num_t CSR_SAVE2  = 14'h032;
  localparam csr_num_t CSR_SAVE3  = 14'h033;
  localparam csr_num_t CSR_TID    = 14'h040;
  localparam csr_num_t CSR_TCFG   = 14'h041;
  localparam csr_num_t CSR_TVAL   = 14'h042;
  localparam csr_num_t CSR_TICLR  = 14'h044;

  localparam int CRMD_PLV_LSB       = 0;
  localparam int CRMD_PLV_W         = 2;
  localparam int CRMD_IE            = 2;
  localparam int CRMD_DA            = 3;
  localparam int PRMD_PPLV_LSB      = 0;
  localparam int PRMD_PPLV_W        = 2;
  localparam int PRMD_PIE           = 2;
  localparam int ECFG_LIE_W         = 13;
  localparam int ESTAT_IS_W         = 13;
  localparam int ESTAT_IS_SW_LSB    = 0;
  localparam int ESTAT_IS_TI        = 11;
  localparam int ESTAT_ECODE_LSB    = 16;
  localparam int ESTAT_ECODE_W      = 6;
  localparam int ESTAT_ESUBCODE_LSB = 22;
  localparam int ESTAT_ESUBCODE_W   = 9;
  localparam int EENTRY_VA_LSB      = 6;
  localparam int TCFG_EN            = 0;
  localparam int TCFG_PERIODIC      = 1;
  localparam int TCFG_INITV_LSB     = 2;

  // LIE bit 10 does not exist, so it is forced to zero on every write
  localparam logic [ECFG_LIE_W-1:0] ECFG_LIE_MASK = 13'h1bff;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (old_val & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access and write-back commit bundle between the pipeline (master) and csr_regfile (slave).
interface csr_regfile_if;
  import csr_defs::*;

  logic        csr_re;
  csr_num_t    csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode,
    input  csr_rvalue
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode,
    output csr_rvalue
  );

endinterface

// File: rtl/csr_regfile_timer.sv
// Stable timer: holds TCFG/TVAL and the ESTAT.IS[11] timer-interrupt flag.
// Only instantiated when CSR_TIMER_EN is defined.
module csr_timer
  import csr_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tcfg_we,
  input  logic [31:0] i_tcfg_wdata,
  input  logic        i_ticlr,
  output logic [31:0] o_tcfg,
  output logic [31:0] o_tval,
  output logic        o_timer_int
);

  logic [31:0] r_tcfg;
  logic [31:0] r_tval;
  logic        r_timer_int;

  // All-ones TVAL marks an expired one-shot timer and stops counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcfg <= '0;
      r_tval <= '0;
    end else begin
      if (i_tcfg_we) begin
        r_tcfg <= i_tcfg_wdata;
      end
      if (i_tcfg_we && i_tcfg_wdata[TCFG_EN]) begin
        r_tval <= {i_tcfg_wdata[31:TCFG_INITV_LSB], 2'b00};
      end else if (r_tcfg[TCFG_EN] && (r_tval != '1)) begin
        if ((r_tval == '0) && r_tcfg[TCFG_PERIODIC]) begin
          r_tval <= {r_tcfg[31:TCFG_INITV_LSB], 2'b00};
        end else begin
          r_tval <= r_tval - 32'd1;
        end
      end
    end
  end

  // A clear in the same cycle as a set takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer_int <= 1'b0;
    end else if (i_ticlr) begin
      r_timer_int <= 1'b0;
    end else if (r_tcfg[TCFG_EN] && (r_tval == '0)) begin
      r_timer_int <= 1'b1;
    end
  end

  assign o_tcfg      = r_tcfg;
  assign o_tval      = r_tval;
  assign o_timer_int = r_timer_int;

endmodule

// File: rtl/csr_regfile.sv
// LoongArch CSR register file: masked CSR writes, exception/ertn side effects, interrupt pending.
// Define CSR_TIMER_EN to include TID/TCFG/TVAL/TICLR and the timer interrupt.
module csr_regfile
  import csr_defs::*;
(
  input  logic          clk,
  input  logic          reset,
  csr_regfile_if.slave  csr,
  input  logic [7:0]    hw_int_in,
  input  logic          ipi_int_in,
  output logic [31:0]   ex_entry,
  output logic [31:0]   ertn_entry,
  output logic          has_int
);

  logic [CRMD_PLV_W-1:0]       r_crmd_plv;
  logic                        r_crmd_ie;
  logic                        r_crmd_da;
  logic [PRMD_PPLV_W-1:0]      r_prmd_pplv;
  logic                        r_prmd_pie;
  logic [ECFG_LIE_W-1:0]       r_ecfg_lie;
  logic [1:0]                  r_estat_is_sw;
  logic [7:0]                  r_estat_is_hw;
  logic                        r_estat_is_ipi;
  logic [ESTAT_ECODE_W-1:0]    r_estat_ecode;
  logic [ESTAT_ESUBCODE_W-1:0] r_estat_esubcode;
  logic [31:0]                 r_era;
  logic [31:EENTRY_VA_LSB]     r_eentry_va;
  logic [31:0]                 r_save [0:3];

  logic                        w_we;
  logic [31:0]                 w_rdata;
  logic [31:0]                 w_new;
  logic [ESTAT_IS_W-1:0]       w_is;
  logic                        w_timer_int;
  logic                        w_unused;

  // Commit side effects win over software writes, which are then dropped whole
  assign w_we    = csr.csr_we & ~csr.wb_ex & ~csr.ertn_flush;
  assign w_new   = csr_merge(w_rdata, csr.csr_wmask, csr.csr_wvalue);
  assign w_unused = csr.csr_re;

`ifdef CSR_TIMER_EN
  logic [31:0] r_tid;
  logic [31:0] w_tcfg;
  logic [31:0] w_tval;

  csr_timer u_timer (
    .clk          (clk),
    .rst          (reset),
    .i_tcfg_we    (w_we && (csr.csr_num == CSR_TCFG)),
    .i_tcfg_wdata (w_new),
    .i_ticlr      (w_we && (csr.csr_num == CSR_TICLR) && csr.csr_wvalue[0] && csr.csr_wmask[0]),
    .o_tcfg       (w_tcfg),
    .o_tval       (w_tval),
    .o_timer_int  (w_timer_int)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tid <= '0;
    end else if (w_we && (csr.csr_num == CSR_TID)) begin
      r_tid <= w_new;
    end
  end
`else
  assign w_timer_int = 1'b0;
`endif

  assign w_is = {r_estat_is_ipi, w_timer_int, 1'b0, r_estat_is_hw, r_estat_is_sw};

  always_comb begin
    w_rdata = '0;
    case (csr.csr_num)
      CSR_CRMD:   w_rdata = {28'b0, r_crmd_da, r_crmd_ie, r_crmd_plv};
      CSR_PRMD:   w_rdata = {29'b0, r_prmd_pie, r_prmd_pplv};
      CSR_ECFG:   w_rdata = {19'b0, r_ecfg_lie};
      CSR_ESTAT:  w_rdata = {1'b0, r_estat_esubcode, r_estat_ecode, 3'b0, w_is};
      CSR_ERA:    w_rdata = r_era;
      CSR_EENTRY: w_rdata = {r_eentry_va, 6'b0};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                  w_rdata = r_save[csr.csr_num[1:0]];
`ifdef CSR_TIMER_EN
      CSR_TID:    w_rdata = r_tid;
      CSR_TCFG:   w_rdata = w_tcfg;
      CSR_TVAL:   w_rdata = w_tval;
`endif
      default:    w_rdata = '0;
    endcase
  end

  assign csr.csr_rvalue = w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crmd_plv  <= '0;
      r_crmd_ie   <= 1'b0;
      r_crmd_da   <= 1'b1;
      r_prmd_pplv <= '0;
      r_prmd_pie  <= 1'b0;
    end else if (csr.wb_ex) begin
      r_prmd_pplv <= r_crmd_plv;
      r_prmd_pie  <= r_crmd_ie;
      r_crmd_plv  <= '0;
      r_crmd_ie   <= 1'b0;
    end else if (csr.ertn_flush) begin
      r_crmd_plv  <= r_prmd_pplv;
      r_crmd_ie   <= r_prmd_pie;
    end else if (w_we && (csr.csr_num == CSR_CRMD)) begin
      r_crmd_plv  <= w_new[CRMD_PLV_LSB +: CRMD_PLV_W];
      r_crmd_ie   <= w_new[CRMD_IE];
      r_crmd_da   <= w_new[CRMD_DA];
    end else if (w_we && (csr.csr_num == CSR_PRMD)) begin
      r_prmd_pplv <= w_new[PRMD_PPLV_LSB +: PRMD_PPLV_W];
      r_prmd_pie  <= w_new[PRMD_PIE];
    end
  end

  // Hardware and IPI levels are resampled every cycle regardless of writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estat_is_sw    <= '0;
      r_estat_is_hw    <= '0;
      r_estat_is_ipi   <= 1'b0;
      r_estat_ecode    <= '0;
      r_estat_esubcode <= '0;
    end else begin
      r_estat_is_hw  <= hw_int_in;
      r_estat_is_ipi <= ipi_int_in;
      if (csr.wb_ex) begin
        r_estat_ecode    <= csr.wb_ecode;
        r_estat_esubcode <= csr.wb_esubcode;
      end else if (w_we && (csr.csr_num == CSR_ESTAT)) begin
        r_estat_is_sw <= w_new[ESTAT_IS_SW_LSB +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_era       <= '0;
      r_eentry_va <= '0;
      r_ecfg_lie  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_save[i] <= '0;
      end
    end else if (csr.wb_ex) begin
      r_era <= csr.wb_pc;
    end else if (w_we) begin
      case (csr.csr_num)
        CSR_ERA:    r_era       <= w_new;
        CSR_EENTRY: r_eentry_va <= w_new[31:EENTRY_VA_LSB];
        CSR_ECFG:   r_ecfg_lie  <= w_new[ECFG_LIE_W-1:0] & ECFG_LIE_MASK;
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                    r_save[csr.csr_num[1:0]] <= w_new;
        default: ;
      endcase
    end
  end

  assign ex_entry   = {r_eentry_va, 6'b0};
  assign ertn_entry = r_era;
  assign has_int    = r_crmd_ie & (|(w_is & r_ecfg_lie));

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile; timer checks are compiled in when CSR_TIMER_EN is defined.
module tb_csr_regfile;
  import csr_defs::*;

  localparam int K_RD   = 0;
  localparam int K_INT  = 1;
  localparam int K_EX   = 2;
  localparam int K_ERTN = 3;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  csr_regfile_if bus ();

  csr_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .csr        (bus.slave),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .ex_entry   (ex_entry),
    .ertn_entry (ertn_entry),
    .has_int    (has_int)
  );

  exp_t scoreQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  logic endCheck   = 1'b0;
  logic endDone    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented read pops one expectation and compares it
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    if (bus.csr_re) begin
      checkCount++;
      if (scoreQ.size() == 0) begin
        $display("[TB] FAIL unexpected_read actual=%h required=no_pending_expectation", bus.csr_rvalue);
      end else begin
        e = scoreQ.pop_front();
        case (e.kind)
          K_RD:    act = bus.csr_rvalue;
          K_INT:   act = {31'b0, has_int};
          K_EX:    act = ex_entry;
          default: act = ertn_entry;
        endcase
        if (act === e.exp) passCount++;
        else $display("[TB] FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
    if (endCheck && !endDone) begin
      endDone = 1'b1;
      checkCount++;
      if (scoreQ.size() == 0) passCount++;
      else $display("[TB] FAIL scoreboard_drain actual=%0d required=0", scoreQ.size());
    end
  end

  task automatic checkOutput(input int kind, input logic [13:0] num,
                             input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = exp;
    scoreQ.push_back(e);
    bus.csr_num = num;
    bus.csr_re  = 1'b1;
    @(negedge clk);
    #1 bus.csr_re = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [13:0] num, input logic [31:0] mask,
                               input logic [31:0] val);
    bus.csr_num    = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    bus.csr_we     = 1'b1;
    @(posedge clk);
    #1 bus.csr_we = 1'b0;
  endtask

  task automatic raiseException(input logic [31:0] pc, input logic [5:0] ecode,
                                input logic [8:0] esub);
    bus.wb_pc       = pc;
    bus.wb_ecode    = ecode;
    bus.wb_esubcode = esub;
    bus.wb_ex       = 1'b1;
    @(posedge clk);
    #1 bus.wb_ex = 1'b0;
  endtask

  task automatic ertnCommit();
    bus.ertn_flush = 1'b1;
    @(posedge clk);
    #1 bus.ertn_flush = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset          = 1'b1;
    hw_int_in      = '0;
    ipi_int_in     = 1'b0;
    bus.csr_re     = 1'b0;
    bus.csr_num    = '0;
    bus.csr_we     = 1'b0;
    bus.csr_wmask  = '0;
    bus.csr_wvalue = '0;
    bus.wb_ex      = 1'b0;
    bus.ertn_flush = 1'b0;
    bus.wb_pc      = '0;
    bus.wb_ecode   = '0;
    bus.wb_esubcode = '0;
    @(posedge clk);
    #1;

    checkOutput(K_RD,  CSR_CRMD, 32'h8, "reset_crmd");
    checkOutput(K_INT, CSR_CRMD, 32'h0, "reset_has_int");
    checkOutput(K_EX,  CSR_CRMD, 32'h0, "reset_ex_entry");
    reset = 1'b0;
    checkOutput(K_RD,   CSR_EENTRY, 32'h0, "eentry_init");
    checkOutput(K_ERTN, CSR_ERA,    32'h0, "ertn_entry_init");

    // Write and read SAVE2 in the same cycle: read must see the old value
    bus.csr_wmask  = 32'hFFFF0000;
    bus.csr_wvalue = 32'hDEADBEEF;
    bus.csr_we     = 1'b1;
    checkOutput(K_RD, CSR_SAVE2, 32'h0, "save2_same_cycle");
    bus.csr_we     = 1'b0;
    checkOutput(K_RD, CSR_SAVE2, 32'hDEAD0000, "save2_masked");

    applyStimulus(CSR_CRMD, 32'h7, 32'h7);
    checkOutput(K_RD, CSR_CRMD, 32'hF, "crmd_plv3_ie1");
    applyStimulus(CSR_EENTRY, 32'hFFFFFFFF, 32'h1C008047);
    checkOutput(K_RD, CSR_EENTRY, 32'h1C008040, "eentry_low_bits_zero");
    checkOutput(K_EX, CSR_EENTRY, 32'h1C008040, "ex_entry_follows");

    raiseException(32'h1C000100, 6'hB, 9'h0);
    checkOutput(K_RD,   CSR_CRMD,  32'h8,        "ex_crmd");
    checkOutput(K_RD,   CSR_PRMD,  32'h7,        "ex_prmd");
    checkOutput(K_RD,   CSR_ERA,   32'h1C000100, "ex_era");
    checkOutput(K_RD,   CSR_ESTAT, 32'h000B0000, "ex_estat");
    checkOutput(K_ERTN, CSR_ERA,   32'h1C000100, "ertn_entry_follows");
    ertnCommit();
    checkOutput(K_RD, CSR_CRMD, 32'hF, "ertn_crmd");

    // Exception and an ERA write in the same cycle: the write is dropped
    bus.csr_num     = CSR_ERA;
    bus.csr_wmask   = 32'hFFFFFFFF;
    bus.csr_wvalue  = 32'h12345678;
    bus.csr_we      = 1'b1;
    bus.wb_pc       = 32'h1C000200;
    bus.wb_ecode    = 6'h3;
    bus.wb_esubcode = 9'h1;
    bus.wb_ex       = 1'b1;
    @(posedge clk);
    #1;
    bus.csr_we = 1'b0;
    bus.wb_ex  = 1'b0;
    checkOutput(K_RD, CSR_ERA,   32'h1C000200, "ex_beats_write_era");
    checkOutput(K_RD, CSR_ESTAT, 32'h00430000, "ex_estat_subcode");
    checkOutput(K_RD, CSR_PRMD,  32'h7,        "ex_prmd_again");

    applyStimulus(14'h007, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput(K_RD, 14'h007, 32'h0, "unimplemented_reads_zero");
    applyStimulus(CSR_ECFG, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput(K_RD, CSR_ECFG, 32'h1BFF, "ecfg_writable_bits");
    applyStimulus(CSR_ESTAT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput(K_RD, CSR_ESTAT, 32'h00430003, "estat_only_sw_is");
    applyStimulus(CSR_ESTAT, 32'h3, 32'h0);

    applyStimulus(CSR_ECFG, 32'hFFFFFFFF, 32'h10);
    applyStimulus(CSR_CRMD, 32'h4, 32'h4);
    checkOutput(K_RD, CSR_CRMD, 32'hC, "crmd_ie_set");
    hw_int_in = 8'h04;
    checkOutput(K_INT, CSR_CRMD,  32'h0,        "hw_int_not_yet");
    checkOutput(K_INT, CSR_CRMD,  32'h1,        "hw_int_pending");
    checkOutput(K_RD,  CSR_ESTAT, 32'h00430010, "estat_hw_is");
    hw_int_in  = 8'h00;
    ipi_int_in = 1'b1;
    checkOutput(K_INT, CSR_CRMD,  32'h1,        "hw_int_lag");
    checkOutput(K_RD,  CSR_ESTAT, 32'h00431000, "estat_ipi");
    ipi_int_in = 1'b0;
    checkOutput(K_INT, CSR_CRMD,  32'h0,        "ipi_not_enabled");

`ifdef CSR_TIMER_EN
    applyStimulus(CSR_ECFG, 32'hFFFFFFFF, 32'h800);
    applyStimulus(CSR_TID, 32'hFFFFFFFF, 32'h55);
    checkOutput(K_RD, CSR_TID, 32'h55, "tid_rw");
    applyStimulus(CSR_TCFG, 32'hFFFFFFFF, 32'hB);
    for (int v = 8; v >= 0; v--) begin
      checkOutput(K_RD, CSR_TVAL, v, "tval_count");
    end
    checkOutput(K_INT, CSR_CRMD,  32'h1,        "timer_has_int");
    checkOutput(K_RD,  CSR_TVAL,  32'h7,        "tval_reloaded");
    checkOutput(K_RD,  CSR_ESTAT, 32'h00430800, "estat_timer_is");
    checkOutput(K_RD,  CSR_TCFG,  32'hB,        "tcfg_readback");
    applyStimulus(CSR_TICLR, 32'h1, 32'h1);
    checkOutput(K_INT, CSR_CRMD,  32'h0,        "ticlr_clears");
    checkOutput(K_RD,  CSR_TICLR, 32'h0,        "ticlr_reads_zero");
    reset = 1'b1;
    checkOutput(K_RD, CSR_TVAL, 32'h0, "reset_tval_mid_count");
    checkOutput(K_RD, CSR_TCFG, 32'h0, "reset_tcfg");
`else
    applyStimulus(CSR_TCFG, 32'hFFFFFFFF, 32'hB);
    checkOutput(K_RD, CSR_TCFG, 32'h0, "tcfg_absent");
    checkOutput(K_RD, CSR_TVAL, 32'h0, "tval_absent");
    reset = 1'b1;
`endif

    checkOutput(K_RD,   CSR_CRMD,  32'h8, "reset_async_crmd");
    checkOutput(K_INT,  CSR_CRMD,  32'h0, "reset_async_has_int");
    checkOutput(K_EX,   CSR_CRMD,  32'h0, "reset_async_ex_entry");
    checkOutput(K_ERTN, CSR_CRMD,  32'h0, "reset_async_ertn_entry");
    checkOutput(K_RD,   CSR_PRMD,  32'h0, "reset_async_prmd");
    checkOutput(K_RD,   CSR_SAVE2, 32'h0, "reset_async_save2");
    checkOutput(K_RD,   CSR_ESTAT, 32'h0, "reset_async_estat");
    reset = 1'b0;
    checkOutput(K_RD, CSR_CRMD, 32'h8, "post_reset_crmd");

    endCheck = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
